// File: rtl/fir_filter_mc_if.sv
// fir_filter_mc_if: sample input, coefficient-load and filtered-output bus of fir_filter_mc.
// master = sample source / controller side, slave = the filter.
interface fir_filter_mc_if #(
    parameter int unsigned N       = 4,
    parameter int unsigned C       = 2,
    parameter int unsigned WIDTH_X = 8,
    parameter int unsigned WIDTH_B = 8,
    parameter int unsigned WIDTH_Y = 16
);
    localparam int unsigned CH_W = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned K_W  = (N > 1) ? $clog2(N) : 1;

    logic signed [WIDTH_X-1:0] x;
    logic [CH_W-1:0]           x_ch;
    logic                      x_valid;
    logic                      x_ready;
    logic                      coef_we;
    logic [K_W-1:0]            coef_addr;
    logic signed [WIDTH_B-1:0] coef_data;
    logic signed [WIDTH_Y-1:0] y;
    logic [CH_W-1:0]           y_ch;
    logic                      y_valid;
    logic                      y_ready;

    modport master (
        output x, x_ch, x_valid, coef_we, coef_addr, coef_data, y_ready,
        input  x_ready, y, y_ch, y_valid
    );

    modport slave (
        input  x, x_ch, x_valid, coef_we, coef_addr, coef_data, y_ready,
        output x_ready, y, y_ch, y_valid
    );
endinterface

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: time-multiplexed multi-channel FIR, one shared MAC evaluating N taps per sample.
// Define FIR_FILTER_MC_SAT_EN to saturate out-of-range results instead of wrapping them.
module fir_filter_mc #(
    parameter int unsigned N       = 4,
    parameter int unsigned C       = 2,
    parameter int unsigned WIDTH_X = 8,
    parameter int unsigned WIDTH_B = 8,
    parameter int unsigned WIDTH_Y = 16,
    parameter int unsigned SHIFT   = 0
) (
    input  logic           clk,
    input  logic           rst,
    fir_filter_mc_if.slave bus
);
    localparam int unsigned WIDTH_A = WIDTH_X + WIDTH_B + $clog2(N);
    localparam int unsigned CH_W    = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned K_W     = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic signed [WIDTH_X-1:0] z_q [C][N];
    logic signed [WIDTH_X-1:0] z_d [C][N];
    logic [K_W-1:0]            ptr_q [C];
    logic [K_W-1:0]            ptr_d [C];
    logic signed [WIDTH_B-1:0] coef_q [N];
    logic signed [WIDTH_B-1:0] coef_d [N];
    logic signed [WIDTH_A-1:0] acc_q, acc_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic signed [WIDTH_Y-1:0] y_q, y_d;
    logic [CH_W-1:0]           y_ch_q, y_ch_d;
    logic                      y_valid_q, y_valid_d;

    logic [K_W-1:0]            tap_idx_c;
    logic signed [WIDTH_A-1:0] prod_c;
    logic signed [WIDTH_A-1:0] shifted_c;
    logic signed [WIDTH_Y-1:0] y_fmt_c;
    logic                      x_ch_ok_c;
    logic                      coef_addr_ok_c;

    assign x_ch_ok_c      = 32'(bus.x_ch) < C;
    assign coef_addr_ok_c = 32'(bus.coef_addr) < N;

    // Tap k reads the sample k steps older than the newest one, modulo N.
    always_comb begin
        if (ptr_q[ch_q] >= k_q) begin
            tap_idx_c = ptr_q[ch_q] - k_q;
        end else begin
            tap_idx_c = K_W'(ptr_q[ch_q] + K_W'(N) - k_q);
        end
        prod_c    = WIDTH_A'(z_q[ch_q][tap_idx_c]) * WIDTH_A'(coef_q[k_q]);
        shifted_c = acc_q >>> SHIFT;
    end

    // Output reduction: only meaningful when the shifted accumulator can exceed WIDTH_Y.
    if (WIDTH_A > WIDTH_Y) begin : g_narrow
`ifdef FIR_FILTER_MC_SAT_EN
        logic [WIDTH_A-WIDTH_Y:0] top_c;
        assign top_c = shifted_c[WIDTH_A-1:WIDTH_Y-1];
        always_comb begin
            if ((&top_c) || !(|top_c)) begin
                y_fmt_c = WIDTH_Y'(shifted_c);
            end else if (shifted_c[WIDTH_A-1]) begin
                y_fmt_c = {1'b1, {(WIDTH_Y-1){1'b0}}};
            end else begin
                y_fmt_c = {1'b0, {(WIDTH_Y-1){1'b1}}};
            end
        end
`else
        assign y_fmt_c = WIDTH_Y'(shifted_c);
`endif
    end else begin : g_wide
        assign y_fmt_c = WIDTH_Y'(shifted_c);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        z_d       = z_q;
        ptr_d     = ptr_q;
        coef_d    = coef_q;
        acc_d     = acc_q;
        k_d       = k_q;
        ch_d      = ch_q;
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        y_valid_d = y_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.coef_we && coef_addr_ok_c) begin
                    coef_d[bus.coef_addr] = bus.coef_data;
                end
                if (bus.x_valid && x_ch_ok_c) begin
                    ch_d                            = bus.x_ch;
                    z_d[bus.x_ch][ptr_q[bus.x_ch]] = bus.x;
                    acc_d                           = '0;
                    k_d                             = '0;
                    state_d                         = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_c;
                if (k_q == K_W'(N - 1)) begin
                    ptr_d[ch_q] = (ptr_q[ch_q] == K_W'(N - 1)) ? '0 : ptr_q[ch_q] + K_W'(1);
                    state_d     = S_OUT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_OUT: begin
                // First OUT cycle loads the result; it then holds until accepted.
                if (!y_valid_q) begin
                    y_d       = y_fmt_c;
                    y_ch_d    = ch_q;
                    y_valid_d = 1'b1;
                end else if (bus.y_ready) begin
                    y_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            z_q       <= '{default: '{default: '0}};
            ptr_q     <= '{default: '0};
            coef_q    <= '{default: '0};
            acc_q     <= '0;
            k_q       <= '0;
            ch_q      <= '0;
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            z_q       <= z_d;
            ptr_q     <= ptr_d;
            coef_q    <= coef_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            ch_q      <= ch_d;
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.x_ready = (state_q == S_IDLE);
    assign bus.y       = y_q;
    assign bus.y_ch    = y_ch_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_filter_mc.sv
// Bench for fir_filter_mc: vector tables plus hand sequences for latency, backpressure,
// busy coefficient writes and mid-operation reset; outputs are checked from an expectation queue.
module tb_fir_filter_mc;
    localparam int unsigned N       = 4;
    localparam int unsigned C       = 2;
    localparam int unsigned WIDTH_X = 8;
    localparam int unsigned WIDTH_B = 8;
    localparam int unsigned WIDTH_Y = 16;
    localparam int unsigned CH_W    = 1;
    localparam int unsigned K_W     = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fir_filter_mc_if #(.N(N), .C(C), .WIDTH_X(WIDTH_X), .WIDTH_B(WIDTH_B), .WIDTH_Y(WIDTH_Y)) bus();

    fir_filter_mc #(
        .N(N), .C(C), .WIDTH_X(WIDTH_X), .WIDTH_B(WIDTH_B), .WIDTH_Y(WIDTH_Y), .SHIFT(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int ch;
        int x;
        int exp_y;
    } vec_t;

    typedef struct {
        int ch;
        int y;
    } exp_t;

    exp_t exp_q[$];
    int   coef_m [N];
    int   hist_m [C][N];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.y_valid && bus.y_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got y=%0d ch=%0d, expected no output",
                         bus.y, bus.y_ch);
            end else begin
                e = exp_q.pop_front();
                check("y_value", int'(bus.y), e.y);
                check("y_ch", int'(bus.y_ch), e.ch);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            coef_m[k] = 0;
            for (int c = 0; c < C; c++) hist_m[c][k] = 0;
        end
    endtask

    function automatic int model_step(input int ch, input int x);
        longint acc;
        logic signed [WIDTH_Y-1:0] w;
        acc = 0;
        for (int k = N - 1; k > 0; k--) hist_m[ch][k] = hist_m[ch][k-1];
        hist_m[ch][0] = x;
        for (int k = 0; k < N; k++) acc += longint'(coef_m[k]) * longint'(hist_m[ch][k]);
`ifdef FIR_FILTER_MC_SAT_EN
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
`else
        w = WIDTH_Y'(acc);
        return int'(w);
`endif
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        bus.x_valid = 1'b0;
        bus.coef_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        model_clear();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.x_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.x_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: x_ready=0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        wait_idle();
        bus.coef_we   = 1'b1;
        bus.coef_addr = K_W'(addr);
        bus.coef_data = WIDTH_B'(data);
        tick();
        bus.coef_we  = 1'b0;
        coef_m[addr] = data;
    endtask

    task automatic send(input int ch, input int x, input int exp_y);
        exp_t e;
        wait_idle();
        bus.x       = WIDTH_X'(x);
        bus.x_ch    = CH_W'(ch);
        bus.x_valid = 1'b1;
        e.ch        = ch;
        e.y         = exp_y;
        exp_q.push_back(e);
        tick();
        bus.x_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        wait_idle();
    endtask

    initial begin
        vec_t imp_tbl [5];
        vec_t iso_tbl [4];
        vec_t ovf_tbl [4];
        int   lat;

        imp_tbl = '{'{0, 1, 1}, '{0, 0, 2}, '{0, 0, 3}, '{0, 0, 4}, '{0, 0, 0}};
        iso_tbl = '{'{0, 10, 10}, '{1, -1, -1}, '{0, 0, 20}, '{1, 0, -2}};
`ifdef FIR_FILTER_MC_SAT_EN
        ovf_tbl = '{'{0, -128, 16384}, '{0, -128, 32767}, '{0, -128, 32767}, '{0, -128, 32767}};
`else
        ovf_tbl = '{'{0, -128, 16384}, '{0, -128, -32768}, '{0, -128, -16384}, '{0, -128, 0}};
`endif

        bus.x         = '0;
        bus.x_ch      = '0;
        bus.x_valid   = 1'b0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.y_ready   = 1'b1;
        do_reset();

        check("rst_x_ready", int'(bus.x_ready), 1);
        check("rst_y", int'(bus.y), 0);
        check("rst_y_ch", int'(bus.y_ch), 0);
        check("rst_y_valid", int'(bus.y_valid), 0);

        // Impulse response, first entry also measures latency from acceptance edge.
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        send(imp_tbl[0].ch, imp_tbl[0].x, imp_tbl[0].exp_y);
        check("x_ready_after_accept", int'(bus.x_ready), 0);
        lat = 0;
        while (!bus.y_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("first_y_latency", lat, 5);
        for (int i = 1; i < 5; i++) send(imp_tbl[i].ch, imp_tbl[i].x, imp_tbl[i].exp_y);
        drain();

        for (int i = 0; i < 4; i++) send(iso_tbl[i].ch, iso_tbl[i].x, iso_tbl[i].exp_y);
        drain();

        // Coefficient write while busy is dropped; the same write in IDLE applies at once.
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        send(0, 1, 1);
        bus.coef_we   = 1'b1;
        bus.coef_addr = K_W'(0);
        bus.coef_data = WIDTH_B'(5);
        tick();
        bus.coef_we = 1'b0;
        drain();
        send(0, 1, 3);
        drain();
        bus.coef_we   = 1'b1;
        bus.coef_addr = K_W'(0);
        bus.coef_data = WIDTH_B'(5);
        bus.x         = WIDTH_X'(1);
        bus.x_ch      = CH_W'(0);
        bus.x_valid   = 1'b1;
        exp_q.push_back('{ch: 0, y: 10});
        tick();
        bus.coef_we = 1'b0;
        bus.x_valid = 1'b0;
        drain();

        // Backpressure: output held, stray sample refused until the handshake.
        bus.y_ready = 1'b0;
        send(1, 2, 10);
        lat = 0;
        while (!bus.y_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_y_valid_rise", int'(bus.y_valid), 1);
        bus.x       = WIDTH_X'(7);
        bus.x_ch    = CH_W'(1);
        bus.x_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_y_valid_hold", int'(bus.y_valid), 1);
            check("bp_y_hold", int'(bus.y), 10);
            check("bp_y_ch_hold", int'(bus.y_ch), 1);
            check("bp_x_ready_low", int'(bus.x_ready), 0);
        end
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b1;
        drain();
        send(1, 0, 4);
        drain();

        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, -128);
        for (int i = 0; i < 4; i++) send(ovf_tbl[i].ch, ovf_tbl[i].x, ovf_tbl[i].exp_y);
        drain();

        // Reset in the middle of MAC aborts the sample and clears coefficients.
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        wait_idle();
        bus.x       = WIDTH_X'(1);
        bus.x_ch    = CH_W'(0);
        bus.x_valid = 1'b1;
        tick();
        bus.x_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_x_ready", int'(bus.x_ready), 1);
        for (int i = 0; i < 8; i++) begin
            check("rst_mid_no_y_valid", int'(bus.y_valid), 0);
            tick();
        end
        send(0, 1, 0);
        drain();

        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, int'($urandom_range(255)) - 128);
        for (int i = 0; i < 40; i++) begin
            int ch;
            int x;
            ch = int'($urandom_range(C - 1));
            x  = int'($urandom_range(255)) - 128;
            send(ch, x, model_step(ch, x));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
